write_burst_data: RTL

- Write-data stage directly downstream of the burst detector.
- Pops one burst length (AXI encoding: beats-1) from the detector's burst-length FIFO, then forwards exactly that many plus one data words from the write-data FIFO to the AXI W channel.
- Asserts wlast on the final beat of each burst.
- W outputs are registered; bursts issue back-to-back with no bubble.

---
 rtl/write_burst_data.sv | 123 ++++++++++++
 1 files changed

// File: rtl/write_burst_data.sv
// write_burst_data: write-data stage behind the burst detector.
// Pops a burst length (beats-1), then streams that many plus one words
// from the data FIFO onto the AXI W channel, flagging wlast on the final
// beat. The W outputs come straight from flops. A new burst can start on
// the cycle right after the previous final beat loads, so there is no
// bubble between bursts.
module write_burst_data #(
   parameter int DataWidth     = 512,
   parameter int BurstLenWidth = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   // burst-length FIFO (read side)
   input  logic [BurstLenWidth-1:0] burst_len_dout,
   input  logic                     burst_len_empty_n,
   output logic                     burst_len_read,
   // write-data FIFO (read side)
   input  logic [DataWidth-1:0]     data_dout,
   input  logic                     data_empty_n,
   output logic                     data_read,
   // AXI W channel
   output logic [DataWidth-1:0]     m_axi_wdata,
   output logic [DataWidth/8-1:0]   m_axi_wstrb,
   output logic                     m_axi_wlast,
   output logic                     m_axi_wvalid,
   input  logic                     m_axi_wready
);

   typedef enum logic {
      S_IDLE,
      S_BURST
   } state_e;

   state_e                   state_q;
   logic [BurstLenWidth-1:0] remaining_q;
   logic [DataWidth-1:0]     wdata_q;
   logic                     wvalid_q;
   logic                     wlast_q;

   // The output register can take a new beat when it is empty or its
   // current beat is leaving this cycle.
   logic out_free;
   logic last_beat;
   logic w_xfer;

   assign out_free  = !wvalid_q || m_axi_wready;
   assign last_beat = (remaining_q == '0);
   assign w_xfer    = wvalid_q && m_axi_wready;

   // Every lane of a write is always valid.
   assign m_axi_wstrb  = '1;
   assign m_axi_wdata  = wdata_q;
   assign m_axi_wlast  = wlast_q;
   assign m_axi_wvalid = wvalid_q;

   // FIFO pop strobes. In BURST the next length is popped together with the
   // final data beat so the following burst can start one cycle later.
   always_comb begin
      burst_len_read = 1'b0;
      data_read      = 1'b0;
      if (!rst) begin
         case (state_q)
            S_IDLE: begin
               burst_len_read = burst_len_empty_n;
            end
            S_BURST: begin
               data_read      = data_empty_n && out_free;
               burst_len_read = data_read && last_beat && burst_len_empty_n;
            end
            default: begin
               burst_len_read = 1'b0;
               data_read      = 1'b0;
            end
         endcase
      end
   end

   // Burst FSM plus the registered W beat. A beat that has just been
   // accepted is released here unless a new word replaces it in the same
   // cycle. The load below comes later in the block, so its assignments win.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         wdata_q     <= '0;
         wvalid_q    <= 1'b0;
         wlast_q     <= 1'b0;
      end else begin
         if (w_xfer) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (burst_len_read) begin
                  remaining_q <= burst_len_dout;
                  state_q     <= S_BURST;
               end
            end
            S_BURST: begin
               if (data_read) begin
                  wdata_q  <= data_dout;
                  wvalid_q <= 1'b1;
                  wlast_q  <= last_beat;
                  if (!last_beat) begin
                     // only decrements while nonzero, so a full-range length
                     // never wraps
                     remaining_q <= remaining_q - 1'b1;
                  end else if (burst_len_read) begin
                     remaining_q <= burst_len_dout;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
